// File: rtl/instr_memory_block_if.sv
// instr_memory_block_if: cache-side block read handshake plus word programming port
interface instr_memory_block_if;
    logic mem_read;
    logic [5:0] mem_address;
    logic mem_busywait;
    logic [127:0] mem_readdata;
    logic prog_we;
    logic [7:0] prog_addr;
    logic [31:0] prog_data;
    logic prog_busy;
    modport master (
        output mem_read, mem_address, prog_we, prog_addr, prog_data,
        input mem_busywait, mem_readdata, prog_busy
    );
    modport slave (
        input mem_read, mem_address, prog_we, prog_addr, prog_data,
        output mem_busywait, mem_readdata, prog_busy
    );
endinterface

// File: rtl/instr_memory_block.sv
// instr_memory_block: 64 x 128-bit instruction memory with latency-timed block reads
// and a word-wide programming port that is only honoured while idle.
module instr_memory_block #(
    parameter int LATENCY = 4
) (
    input logic clk,
    input logic reset,
    instr_memory_block_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, next;
    logic [7:0] counter;
    logic [5:0] addr;
    logic [127:0] readdata;
    logic [31:0] words [256];
    logic [127:0] block;
    assign block = {words[{addr, 2'd3}], words[{addr, 2'd2}], words[{addr, 2'd1}], words[{addr, 2'd0}]};
    // busywait must rise combinationally with mem_read so the cache never sees a stale "done"
    assign bus.mem_busywait = (state == IDLE && bus.mem_read) || state == BUSY;
    assign bus.mem_readdata = readdata;
    assign bus.prog_busy = state != IDLE;
    always_comb begin
        next = state;
        next = (state == IDLE) ? (bus.mem_read ? BUSY : IDLE) :
               (state == BUSY) ? (!bus.mem_read ? IDLE : (counter == 8'd0 ? DONE : BUSY)) :
               IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            counter <= '0;
            addr <= '0;
            readdata <= '0;
        end else begin
            state <= next;
            if (state == IDLE && bus.mem_read) begin
                addr <= bus.mem_address;
                counter <= 8'(LATENCY - 1);
            end else if (state == BUSY && bus.mem_read) begin
                if (counter == 8'd0) readdata <= block;
                else counter <= counter - 8'd1;
            end
        end
    end
    // storage is deliberately outside reset; a pending read always beats a write
    always_ff @(posedge clk)
        if (!reset && state == IDLE && !bus.mem_read && bus.prog_we)
            words[bus.prog_addr] <= bus.prog_data;
endmodule
